// File: rtl/pll_cen_gen.sv
// Fractional clock-enable generator for one PLL output clock, with lock filtering.
// Optional feature macro: CEN_SQUARE_EN adds the clk_sq square-wave outputs.
module pll_cen_gen #(
  parameter int NUM_CLOCKS = 2,
  parameter int ACC_W      = 32,
  parameter int LOCK_FILT  = 1024,
  localparam int CH_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic                  cfg_reg,
  input  logic [ACC_W-1:0]      cfg_data,
  input  logic                  cfg_sync,
  output logic [NUM_CLOCKS-1:0] cen,
`ifdef CEN_SQUARE_EN
  output logic [NUM_CLOCKS-1:0] clk_sq,
`endif
  output logic                  locked
);

  localparam int CNT_W = $clog2(LOCK_FILT + 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SETTLING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // The carry out of the (ACC_W+1)-bit sum is the channel's enable pulse.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic                  sync1_r;
  logic                  sync2_r;
  logic                  lk_s;
  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  locked_r;
  logic [ACC_W-1:0]      step_r  [NUM_CLOCKS];
  logic [ACC_W-1:0]      phase_r [NUM_CLOCKS];
  logic [ACC_W-1:0]      acc_r   [NUM_CLOCKS];
  logic [ACC_W:0]        sum_s   [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] cen_r;
  logic                  enter_lock_s;
  logic                  run_s;
  logic                  load_s;

  assign lk_s = sync2_r;

  // Two-flop synchroniser for the raw PLL lock.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      sync2_r <= sync1_r;
    end
  end

  // Decode the lock-entry edge and the accumulate/realign conditions.
  always_comb begin
    enter_lock_s = 1'b0;
    case (state_r)
      ST_UNLOCKED: begin
        if (lk_s && (LOCK_FILT == 1)) begin
          enter_lock_s = 1'b1;
        end else begin
          enter_lock_s = 1'b0;
        end
      end
      ST_SETTLING: begin
        if (lk_s && (cnt_r == FILT_LAST)) begin
          enter_lock_s = 1'b1;
        end else begin
          enter_lock_s = 1'b0;
        end
      end
      default: enter_lock_s = 1'b0;
    endcase
    run_s  = (state_r == ST_LOCKED) && lk_s;
    load_s = enter_lock_s || (run_s && cfg_sync);
  end

  // Per-channel accumulator sums.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sum_s[i] = acc_add(acc_r[i], step_r[i]);
    end
  end

  // Lock qualification FSM with registered locked output.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_UNLOCKED;
      cnt_r    <= '0;
      locked_r <= 1'b0;
    end else begin
      case (state_r)
        ST_UNLOCKED: begin
          if (lk_s) begin
            cnt_r <= CNT_W'(1);
            if (enter_lock_s) begin
              state_r  <= ST_LOCKED;
              locked_r <= 1'b1;
            end else begin
              state_r  <= ST_SETTLING;
              locked_r <= 1'b0;
            end
          end else begin
            cnt_r    <= '0;
            locked_r <= 1'b0;
          end
        end
        ST_SETTLING: begin
          if (!lk_s) begin
            state_r  <= ST_UNLOCKED;
            cnt_r    <= '0;
            locked_r <= 1'b0;
          end else if (enter_lock_s) begin
            state_r  <= ST_LOCKED;
            cnt_r    <= cnt_r + CNT_W'(1);
            locked_r <= 1'b1;
          end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
            locked_r <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (!lk_s) begin
            state_r  <= ST_UNLOCKED;
            cnt_r    <= '0;
            locked_r <= 1'b0;
          end else begin
            locked_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_UNLOCKED;
          cnt_r    <= '0;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  // Step/phase register file; out-of-range channel indices match no entry.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        step_r[i]  <= '0;
        phase_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          if (cfg_reg) begin
            phase_r[i] <= cfg_data;
          end else begin
            step_r[i] <= cfg_data;
          end
        end
      end
    end
  end

  // Accumulators: realign on lock entry or sync, run only while locked.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_r[i] <= '0;
      end
      cen_r <= '0;
    end else if (load_s) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_r[i] <= phase_r[i];
      end
      cen_r <= '0;
    end else if (run_s) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc_r[i] <= sum_s[i][ACC_W-1:0];
        cen_r[i] <= sum_s[i][ACC_W];
      end
    end else begin
      cen_r <= '0;
    end
  end

`ifdef CEN_SQUARE_EN
  logic [NUM_CLOCKS-1:0] clk_sq_r;

  // Square wave at f_cen/2 for observation pins, held low outside LOCKED.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      clk_sq_r <= '0;
    end else if (run_s) begin
      clk_sq_r <= clk_sq_r ^ cen_r;
    end else begin
      clk_sq_r <= '0;
    end
  end

  assign clk_sq = clk_sq_r;
`endif

  assign cen    = cen_r;
  assign locked = locked_r;

endmodule

// File: tb/tb_pll_cen_gen.sv
// Scoreboard bench for pll_cen_gen: stimulus queues per-cycle expectations, a monitor compares.
module tb_pll_cen_gen;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       cfg_we = 1'b0;
  logic [0:0] cfg_ch = 1'b0;
  logic       cfg_reg = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_sync = 1'b0;
  logic [1:0] cen;
  logic       locked;

  logic       cfg_we3 = 1'b0;
  logic [1:0] cfg_ch3 = 2'b00;
  logic       sync3 = 1'b0;
  logic [2:0] cen3;
  logic       locked3;

  typedef struct {
    int         cyc;
    int         tag;
    logic       lk;
    logic [1:0] cn;
    logic       mc;
    logic [2:0] c3;
    logic       m3;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   cnt3 = 0;
  int   adj3 = 0;
  logic prev3 = 1'b0;

  always #5 refclk = ~refclk;

  pll_cen_gen #(.NUM_CLOCKS(2), .ACC_W(8), .LOCK_FILT(16)) u_dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_sync(cfg_sync),
    .cen(cen), .locked(locked)
  );

  pll_cen_gen #(.NUM_CLOCKS(3), .ACC_W(8), .LOCK_FILT(16)) u_dut3 (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_we(cfg_we3),
    .cfg_ch(cfg_ch3), .cfg_reg(cfg_reg), .cfg_data(cfg_data), .cfg_sync(sync3),
    .cen(cen3), .locked(locked3)
  );

  always @(posedge refclk) cyc <= cyc + 1;

  task automatic push(input int c, input int tag, input logic lk, input logic [1:0] cn,
                      input logic mc, input logic [2:0] c3, input logic m3);
    exp_t e;
    e.cyc = c; e.tag = tag; e.lk = lk; e.cn = cn; e.mc = mc; e.c3 = c3; e.m3 = m3;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wr(input logic ch, input logic rg, input logic [7:0] d);
    cfg_we = 1'b1; cfg_ch = ch; cfg_reg = rg; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] ch, input logic rg, input logic [7:0] d);
    cfg_we3 = 1'b1; cfg_ch3 = ch; cfg_reg = rg; cfg_data = d;
    tick();
    cfg_we3 = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the expectation scheduled for this cycle.
  always @(negedge refclk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_t%0d cycle %0d not sampled (now %0d)", e.tag, e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (locked !== e.lk) begin
        failures++;
        $display("FAIL locked_t%0d cyc=%0d got=%b want=%b", e.tag, cyc, locked, e.lk);
      end
      if (e.mc) begin
        checks++;
        if (cen !== e.cn) begin
          failures++;
          $display("FAIL cen_t%0d cyc=%0d got=%b want=%b", e.tag, cyc, cen, e.cn);
        end
      end
      if (e.m3) begin
        checks++;
        if ({locked3, cen3} !== {e.lk, e.c3}) begin
          failures++;
          $display("FAIL dut3_t%0d cyc=%0d got=%b want=%b", e.tag, cyc, {locked3, cen3}, {e.lk, e.c3});
        end
      end
      if (e.tag == 3) begin
        if (cen[0] === 1'b1) begin
          cnt3++;
          if (prev3) adj3++;
        end
        prev3 = cen[0];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, e0, s, d, r, n;
    // Reset state, held and just after release.
    tick();
    push(cyc, 0, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1);
    tick();
    push(cyc, 0, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) push(cyc + k, 0, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1);
    wr(1'b0, 1'b0, 8'h80);
    wr(1'b1, 1'b0, 8'h40);
    wr3(2'd0, 1'b0, 8'h80);
    wr3(2'd1, 1'b0, 8'h40);
    wr3(2'd2, 1'b0, 8'h20);
    wr3(2'd3, 1'b0, 8'h10);
    wr3(2'd3, 1'b1, 8'h33);

    // Test 1: lock rises 18 edges after pll_locked, cen quiet while settling.
    c0 = cyc;
    pll_locked = 1'b1;
    for (int k = 1; k <= 17; k++) push(c0 + k, 1, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1);
    push(c0 + 18, 1, 1'b1, 2'b00, 1'b1, 3'b000, 1'b1);
    e0 = c0 + 18;
    // Test 2: periods 2/4 (and 2/4/8 on the 3-channel instance).
    for (int k = 1; k <= 16; k++)
      push(e0 + k, 2, 1'b1, {(k % 4 == 0), (k % 2 == 0)}, 1'b1,
           {(k % 8 == 0), (k % 4 == 0), (k % 2 == 0)}, 1'b1);
    wait_until(e0 + 16);

    // Test 3: step 0x55 over 768 cycles after a realign.
    wr(1'b0, 1'b0, 8'h55);
    cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0;
    s = cyc;
    push(s, 3, 1'b1, 2'b00, 1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= 768; k++)
      push(s + k, 3, 1'b1, {(k % 4 == 0), (((85 * k) % 256) < 85)}, 1'b1, 3'b000, 1'b0);
    wait_until(s + 768);
    tick();
    checks++;
    if (cnt3 != 255) begin
      failures++;
      $display("FAIL pulse_count got=%0d want=255", cnt3);
    end
    checks++;
    if (adj3 != 0) begin
      failures++;
      $display("FAIL adjacent_pulses got=%0d want=0", adj3);
    end

    // Test 4: phase1=0x80, sync with a same-edge phase0 write (old phase used).
    wr(1'b0, 1'b0, 8'h40);
    wr(1'b1, 1'b1, 8'h80);
    cfg_sync = 1'b1; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_reg = 1'b1; cfg_data = 8'h40;
    tick();
    cfg_sync = 1'b0; cfg_we = 1'b0;
    s = cyc;
    for (int k = 0; k <= 14; k++)
      push(s + k, 4, 1'b1, {(k > 0 && k % 4 == 2), (k > 0 && k % 4 == 0)}, 1'b1, 3'b000, 1'b0);
    wait_until(s + 12);

    // Test 5: one-cycle lock drop, relock reloads phases, steps kept.
    d = cyc;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int k = 3; k <= 18; k++) push(d + k, 5, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0);
    push(d + 19, 5, 1'b1, 2'b00, 1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= 12; k++)
      push(d + 19 + k, 5, 1'b1, {(k % 4 == 2), (k % 4 == 3)}, 1'b1, 3'b000, 1'b0);
    wait_until(d + 32);

    // Test 6: async reset in LOCKED and mid-SETTLING; registers cleared, FSM restarts.
    rst = 1'b1;
    push(cyc, 6, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    push(cyc, 6, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    r = cyc;
    for (int k = 1; k <= 17; k++) push(r + k, 6, 1'b0, 2'b00, 1'b1, 3'b000, 1'b0);
    push(r + 18, 6, 1'b1, 2'b00, 1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= 12; k++) push(r + 18 + k, 6, 1'b1, 2'b00, 1'b1, 3'b000, 1'b0);
    wait_until(r + 30);

    // Test 7: maximum step pulses on every cycle but one.
    wr(1'b0, 1'b0, 8'hFF);
    cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0;
    s = cyc;
    push(s, 7, 1'b1, 2'b00, 1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= 20; k++) push(s + k, 7, 1'b1, {1'b0, (k != 1)}, 1'b1, 3'b000, 1'b0);
    wait_until(s + 20);
    tick();

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
